mdu_ctrl: RTL and testbench

- Sequencer for the HI/LO multiply/divide resource of the pipelined MIPS CPU. Sits in the E stage.
- Accepts mult/multu/div/divu/mthi/mtlo commands from the E-stage decode and latches the operands.
- Models multi-cycle latency with a down-counter and commits the results to the HI/LO registers.
- Drives the stall request that holds the pipeline while any HI/LO-using instruction would collide with a busy unit.

---
 rtl/mdu_ctrl.sv | 141 ++++++++++++++
 tb/tb_mdu_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide sequencer for the E stage: latches operands, models
// fixed multi-cycle latency with a down-counter and commits results to HI/LO.
module mdu_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        md_use,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] op_a, op_b;
    logic [31:0] hi_q, lo_q;
    logic        load, commit;

    logic        is_arith;
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b, div_b, q_mag, r_mag;
    logic [63:0] prod;
    logic [31:0] res_hi, res_lo;
    logic        wen;

    assign is_arith = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                      (md_op == OP_DIV)  || (md_op == OP_DIVU);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        commit   = 1'b0;
        case (state)
            IDLE: if (start && is_arith) begin
                state_nx = RUN;
                load     = 1'b1;
            end
            RUN: if (cnt == 4'd1) begin
                state_nx = IDLE;
                commit   = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Signed divide is done on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        neg_a  = op_a[31];
        neg_b  = op_b[31];
        mag_a  = neg_a ? -op_a : op_a;
        mag_b  = neg_b ? -op_b : op_b;
        div_b  = (op_b == 32'd0) ? 32'd1 : op_b;
        q_mag  = mag_a / ((mag_b == 32'd0) ? 32'd1 : mag_b);
        r_mag  = mag_a % ((mag_b == 32'd0) ? 32'd1 : mag_b);
        prod   = 64'd0;
        res_hi = hi_q;
        res_lo = lo_q;
        wen    = 1'b1;
        case (op_q)
            OP_MULT: begin
                prod   = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            OP_MULTU: begin
                prod   = {32'd0, op_a} * {32'd0, op_b};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            OP_DIV: begin
                res_lo = (neg_a ^ neg_b) ? -q_mag : q_mag;
                res_hi = neg_a ? -r_mag : r_mag;
                wen    = (op_b != 32'd0);
            end
            OP_DIVU: begin
                res_lo = op_a / div_b;
                res_hi = op_a % div_b;
                wen    = (op_b != 32'd0);
            end
            default: wen = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= 4'd0;
            op_q <= 3'd0;
            op_a <= 32'd0;
            op_b <= 32'd0;
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            if (load) begin
                op_q <= md_op;
                op_a <= src_a;
                op_b <= src_b;
                cnt  <= ((md_op == OP_MULT) || (md_op == OP_MULTU)) ? 4'(MULT_CYC) : 4'(DIV_CYC);
            end else if (state == RUN) begin
                cnt <= cnt - 4'd1;
            end

            if (commit && wen) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (state == IDLE && start) begin
                if (md_op == OP_MTHI) hi_q <= src_a;
                if (md_op == OP_MTLO) lo_q <= src_a;
            end
        end
    end

    assign busy     = (state == RUN);
    assign md_stall = md_use & (busy | start);
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized self-checking bench for mdu_ctrl against an arithmetic HI/LO model.
module tb_mdu_ctrl;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a, src_b;
    logic        md_use;
    logic        busy, md_stall;
    logic [31:0] hi_out, lo_out;

    int checks   = 0;
    int failures = 0;

    logic [31:0] hi_m = 32'd0;
    logic [31:0] lo_m = 32'd0;

    mdu_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .src_a(src_a), .src_b(src_b), .md_use(md_use),
        .busy(busy), .md_stall(md_stall), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: MIPS HI/LO semantics computed with plain SV arithmetic.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int     sa, sb;
        longint p;
        logic [63:0] pu;
        sa = a;
        sb = b;
        case (op)
            3'd1: begin p = longint'(sa) * longint'(sb); {hi_m, lo_m} = p; end
            3'd2: begin pu = {32'd0, a} * {32'd0, b}; {hi_m, lo_m} = pu; end
            3'd3: if (b != 0) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo_m = 32'h8000_0000; hi_m = 32'd0;
                end else begin
                    lo_m = sa / sb; hi_m = sa % sb;
                end
            end
            3'd4: if (b != 0) begin lo_m = a / b; hi_m = a % b; end
            3'd5: hi_m = a;
            3'd6: lo_m = a;
            default: ;
        endcase
    endtask

    function automatic int latency(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return MULT_CYC;
        if (op == 3'd3 || op == 3'd4) return DIV_CYC;
        return 0;
    endfunction

    // Issues one command; with poke, start stays high with junk operands while busy.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic use_hl, input logic poke);
        int n;
        @(negedge clk);
        start = 1'b1; md_op = op; src_a = a; src_b = b; md_use = use_hl;
        #1;
        check({tag, ".stall_start"}, 64'(md_stall), 64'(use_hl));
        @(negedge clk);
        if (poke) begin
            md_op = 3'($urandom_range(1, 6)); src_a = $urandom; src_b = $urandom;
        end else begin
            start = 1'b0; md_op = 3'd0;
        end
        n = 0;
        while (busy && n < 40) begin
            #1;
            check({tag, ".stall_busy"}, 64'(md_stall), 64'(use_hl));
            n++;
            @(negedge clk);
        end
        start = 1'b0; md_op = 3'd0;
        model(op, a, b);
        check({tag, ".busy_cycles"}, 64'(n), 64'(latency(op)));
        check({tag, ".hi"}, 64'(hi_out), 64'(hi_m));
        check({tag, ".lo"}, 64'(lo_out), 64'(lo_m));
        #1;
        check({tag, ".stall_idle"}, 64'(md_stall), 64'd0);
        md_use = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; md_op = 3'd0; src_a = 32'd0; src_b = 32'd0; md_use = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.stall", 64'(md_stall), 64'd0);
        check("rst.hi", 64'(hi_out), 64'd0);
        check("rst.lo", 64'(lo_out), 64'd0);

        do_op("mult",  3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        check("mult.exp_lo", 64'(lo_out), 64'hFFFF_FFFA);
        do_op("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        check("multu.exp_hi", 64'(hi_out), 64'h2);
        do_op("div",   3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check("div.exp_lo", 64'(lo_out), 64'hFFFF_FFFD);
        check("div.exp_hi", 64'(hi_out), 64'hFFFF_FFFF);
        do_op("mthi",  3'd5, 32'h11, 32'd0, 1'b0, 1'b0);
        do_op("mtlo",  3'd6, 32'h22, 32'd0, 1'b0, 1'b0);
        do_op("div0",  3'd3, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        check("div0.hi_kept", 64'(hi_out), 64'h11);
        check("div0.lo_kept", 64'(lo_out), 64'h22);
        do_op("divu0", 3'd4, 32'h1, 32'd0, 1'b1, 1'b0);
        do_op("mtlo2", 3'd6, 32'h1234, 32'd0, 1'b0, 1'b0);
        check("mtlo2.val", 64'(lo_out), 64'h1234);
        do_op("mthi2", 3'd5, 32'h1234, 32'd0, 1'b0, 1'b0);
        do_op("divovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op("mult_poke", 3'd1, 32'h0001_0003, 32'hFFFF_0005, 1'b1, 1'b1);
        do_op("div_poke",  3'd3, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1'b1);
        do_op("nop0", 3'd0, 32'hDEAD_BEEF, 32'd1, 1'b1, 1'b0);
        do_op("nop7", 3'd7, 32'hDEAD_BEEF, 32'd1, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
            do_op($sformatf("rnd%0d", i), op, a, b, 1'($urandom), 1'($urandom));
        end

        // Abort a divide mid-flight with an asynchronous reset.
        do_op("pre_abort", 3'd6, 32'h55, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1; md_op = 3'd3; src_a = 32'd100; src_b = 32'd7;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        repeat (2) @(negedge clk);
        check("abort.busy_before", 64'(busy), 64'd1);
        #1 reset = 1'b1;
        #1;
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.hi", 64'(hi_out), 64'd0);
        check("abort.lo", 64'(lo_out), 64'd0);
        hi_m = 32'd0; lo_m = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        repeat (DIV_CYC + 2) @(negedge clk);
        check("abort.no_late_busy", 64'(busy), 64'd0);
        check("abort.no_late_lo", 64'(lo_out), 64'd0);
        check("abort.no_late_hi", 64'(hi_out), 64'd0);
        do_op("post_abort", 3'd1, 32'd12345, 32'd678, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
